method_call_arbiter: RTL
========================

# method_call_arbiter

Shares one Synthesijer-generated method instance (req/busy/return handshake) among N_REQ hardware requesters. Arbitration is round-robin. The block muxes the winner's argument onto the method, issues a single-cycle request pulse, tracks busy, latches the return value and signals completion to the winner. It sits between caller logic and a shared compiled method such as a `test()` routine.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ARG_W, 32, method argument width
- RET_W, 32, method return width
- TIMEOUT, 1024, watchdog limit in cycles; only used with the timeout feature
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester call request, level, held until `done[i]`
- arg  in  N_REQ*ARG_W  packed arguments; requester i uses bits [i*ARG_W +: ARG_W]; must be stable while `req[i]` is high
- busy  out  N_REQ  high from grant until `done[i]`
- done  out  N_REQ  one-cycle completion pulse
- err  out  N_REQ  one-cycle pulse coincident with `done[i]` on timeout abort
- ret  out  RET_W  last latched return value; holds until the next completion
- method_req  out  1  one-cycle call pulse to the shared method
- method_arg  out  ARG_W  argument to the method, held from ISSUE through RUN
- method_busy  in  1  method running
- method_return  in  RET_W  method result, valid when `method_busy` falls

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, RUN, DONE.
- IDLE: if any `req` is high, choose the winner g. Search starts at `last+1` and wraps modulo N_REQ. Register g, set `busy[g]`, latch `arg[g]` into `method_arg`, then go to ISSUE.
- ISSUE: `method_req`=1 for exactly this cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for `method_busy`=1, then go to RUN.
- RUN: wait for `method_busy`=0. On that cycle, latch `method_return` into `ret` and go to DONE.
- DONE: `done[g]`=1, clear `busy[g]`, set `last`=g, return to IDLE.
- Requester contract: deassert `req[i]` on the edge after seeing `done[i]`. IDLE then sees it low, so no double call occurs.
- A `req` that rises outside IDLE waits. Non-granted `busy` bits stay 0.
- Dropping `req[g]` after grant does not cancel the call; the call completes normally.
- Reset values: state=IDLE, `last`=N_REQ-1 (so requester 0 wins first), and all outputs 0.
- Reset asserted mid-call aborts immediately with no `done`. The shared method must be reset on the same net.

## Timing
- Minimum call to the method's completion is 4 cycles of arbiter overhead: IDLE→ISSUE→WAIT_BUSY→RUN→DONE, plus the method's busy duration.
- `done[g]` is registered and appears one cycle after `method_busy` is sampled low in RUN.
- Back-to-back: the next grant is decided in the IDLE cycle that follows DONE. `method_req` pulses are therefore at least 5 cycles apart.
- `method_req` never stays high two consecutive cycles.
- Fairness: with all N_REQ requesting continuously, each requester is served once per N_REQ calls.

## Configuration
- `METHOD_ARB_TIMEOUT_EN` defined:
  - A counter of width clog2(TIMEOUT+1) clears on ISSUE and increments in WAIT_BUSY and RUN.
  - When it reaches TIMEOUT, go to DONE with `err[g]`=1. `ret` is not updated.
- Undefined: no counter, `err` tied to 0, and the FSM waits indefinitely.

## Structure
- Shared package holds the state enum (arb_state_t) and a clog2 helper function.
- One sub-module, `rr_pick`: combinational round-robin priority encoder. Inputs are `req` and `last`; outputs are `grant_idx` and `any`.

## Test plan
- Single call: `req[2]`=1, `arg[2]`=5, and a model method that is busy 3 cycles and returns arg*2. Expect one `method_req` pulse, `method_arg`=5, `done[2]` pulse, and `ret`=10.
- Contention: all 4 `req` raised in the same cycle. Expect grant order 0,1,2,3, four `done` pulses, and never two `busy` bits high.
- Fairness after wrap: `last`=3, then `req[1]` and `req[3]`. Expect 1 served before 3.
- Late request: `req[0]` rises while `req[1]` is in RUN. Expect the `req[0]` grant in the IDLE cycle after `done[1]`, and `method_req` pulses ≥5 cycles apart.
- Reset mid-RUN: assert `reset`=0 during RUN. Expect all outputs 0 and state IDLE, with no `done`. After release, a pending `req` is served normally.
- Timeout (with `METHOD_ARB_TIMEOUT_EN`, TIMEOUT=16): the method never raises busy. Expect `done[g]` and `err[g]` together within 17 cycles of ISSUE, and `ret` unchanged.

Source files
------------

// File: rtl/method_call_arbiter_pkg.sv
// Shared definitions for the method call arbiter: FSM state encoding and a
// constant-foldable ceil(log2) helper used to size indices and counters.
package method_call_arbiter_pkg;

   // Arbiter sequencing states, one per phase of a shared-method call.
   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      RUN,
      DONE
   } arb_state_t;

   // Smallest r such that 2**r >= value. Used only at elaboration time.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/method_call_arbiter_rr_pick.sv
// Round-robin priority encoder. The search begins one past the requester that
// was served last and wraps, so the most recently served requester has the
// lowest priority on the next decision.
module rr_pick
   import method_call_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   localparam int IDX_W = clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   output logic [IDX_W-1:0] grant_idx,
   output logic             any
);

   int               cand;
   logic [IDX_W-1:0] candIdx;

   // Walk the candidates from farthest to nearest so the nearest active
   // requester after 'last' is the one left in grant_idx.
   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      cand      = 0;
      candIdx   = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand    = (int'(last) + k) % N_REQ;
         candIdx = IDX_W'(cand);
         if (req[candIdx]) begin
            grant_idx = candIdx;
            any       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/method_call_arbiter.sv
// Shares one req/busy/return style compiled method among N_REQ requesters.
// A round-robin winner has its argument latched onto the method, the method
// gets a single-cycle request pulse, and when the method drops busy the
// return value is latched and a done pulse goes back to the winner.
//
// Optional watchdog: define METHOD_ARB_TIMEOUT_EN to abort a call that stays
// in WAIT_BUSY/RUN for TIMEOUT cycles; the abort raises err together with
// done and leaves ret untouched. Without the macro err is constant 0 and the
// arbiter waits on the method indefinitely.
module method_call_arbiter
   import method_call_arbiter_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int ARG_W   = 32,
   parameter int RET_W   = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*ARG_W-1:0] arg,
   output logic [N_REQ-1:0]       busy,
   output logic [N_REQ-1:0]       done,
   output logic [N_REQ-1:0]       err,
   output logic [RET_W-1:0]       ret,
   output logic                   method_req,
   output logic [ARG_W-1:0]       method_arg,
   input  logic                   method_busy,
   input  logic [RET_W-1:0]       method_return
);

   localparam int IDX_W = clog2(N_REQ);
   localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

   // Out-of-range configurations leave this block empty on purpose; it only
   // documents the legal parameter space next to the parameters themselves.
   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_param_range
   end

   arb_state_t       state_q;
   logic [IDX_W-1:0] grant_q;
   logic [IDX_W-1:0] last_q;
   logic [N_REQ-1:0] busy_q;
   logic [N_REQ-1:0] done_q;
   logic [RET_W-1:0] ret_q;
   logic             method_req_q;
   logic [ARG_W-1:0] method_arg_q;

   logic [IDX_W-1:0] grant_d;
   logic             any_req_d;
   logic             timeout_hit;
   logic [ARG_W-1:0] argArr [N_REQ];

   // Unpack the flat argument bus so the winner can be selected by index.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         argArr[i] = arg[i*ARG_W +: ARG_W];
      end
   end

   rr_pick #(
      .N_REQ(N_REQ)
   ) u_rr_pick (
      .req      (req),
      .last     (last_q),
      .grant_idx(grant_d),
      .any      (any_req_d)
   );

`ifdef METHOD_ARB_TIMEOUT_EN
   localparam int TMR_W = clog2(TIMEOUT + 1);

   logic [TMR_W-1:0] timer_q;
   logic [N_REQ-1:0] err_q;

   // Watchdog counter: zeroed while the request pulse is out, then counts
   // every cycle spent waiting on the method.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timer_q <= '0;
      end else if (state_q == ISSUE) begin
         timer_q <= '0;
      end else if (state_q == WAIT_BUSY || state_q == RUN) begin
         timer_q <= timer_q + 1'b1;
      end
   end

   // The count reaches TIMEOUT on this edge, so the abort is taken now.
   assign timeout_hit = (timer_q == TMR_W'(TIMEOUT - 1));
   assign err         = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = '0;
`endif

   // Main call sequencer; every output is driven from a register here so the
   // requesters and the method only ever see glitch-free levels and pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_q       <= IDX_W'(N_REQ - 1);
         busy_q       <= '0;
         done_q       <= '0;
         ret_q        <= '0;
         method_req_q <= 1'b0;
         method_arg_q <= '0;
`ifdef METHOD_ARB_TIMEOUT_EN
         err_q        <= '0;
`endif
      end else begin
         method_req_q <= 1'b0;
         done_q       <= '0;
`ifdef METHOD_ARB_TIMEOUT_EN
         err_q        <= '0;
`endif
         unique case (state_q)
            IDLE: begin
               if (any_req_d) begin
                  grant_q      <= grant_d;
                  busy_q       <= ONE_HOT0 << grant_d;
                  method_arg_q <= argArr[grant_d];
                  method_req_q <= 1'b1;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (method_busy) begin
                  state_q <= RUN;
               end else if (timeout_hit) begin
                  done_q  <= ONE_HOT0 << grant_q;
                  busy_q  <= '0;
                  last_q  <= grant_q;
                  state_q <= DONE;
`ifdef METHOD_ARB_TIMEOUT_EN
                  err_q   <= ONE_HOT0 << grant_q;
`endif
               end
            end
            RUN: begin
               if (!method_busy) begin
                  ret_q   <= method_return;
                  done_q  <= ONE_HOT0 << grant_q;
                  busy_q  <= '0;
                  last_q  <= grant_q;
                  state_q <= DONE;
               end else if (timeout_hit) begin
                  done_q  <= ONE_HOT0 << grant_q;
                  busy_q  <= '0;
                  last_q  <= grant_q;
                  state_q <= DONE;
`ifdef METHOD_ARB_TIMEOUT_EN
                  err_q   <= ONE_HOT0 << grant_q;
`endif
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign ret        = ret_q;
   assign method_req = method_req_q;
   assign method_arg = method_arg_q;

endmodule
